tile_link_uncached_ram_responder: RTL
=====================================

# tile_link_uncached_ram_responder

Manager-side endpoint for the uncached TileLink channel produced by the memory interconnect. It accepts Acquire messages (Get, GetBlock, Put, PutBlock) on its inbound port and services them from an internal synchronous 64-bit-wide RAM. It returns matching Grant messages. It sits directly behind the interconnect's `io_out_0` port as an on-chip scratchpad/boot memory.

## Interface
Parameters:
- `BLOCK_IDX_W`, default 6: number of low `addr_block` bits used as the RAM block index. Depth = 2^BLOCK_IDX_W blocks x 8 beats x 64 bits. Upper `addr_block` bits are ignored, so addresses alias.
- `BEAT_W`, default 3: beat index width. Fixed at 8 beats per block.

Ports:
- `clk` in 1: single clock.
- `reset` in 1: asynchronous, active-high.
- `io_in_acquire_ready` out 1: responder can accept an Acquire beat.
- `io_in_acquire_valid` in 1.
- `io_in_acquire_bits_addr_block` in 26.
- `io_in_acquire_bits_client_xact_id` in 2.
- `io_in_acquire_bits_addr_beat` in 3.
- `io_in_acquire_bits_is_builtin_type` in 1.
- `io_in_acquire_bits_a_type` in 3: 0 Get, 1 GetBlock, 2 Put, 3 PutBlock; all other values are unsupported.
- `io_in_acquire_bits_union` in 12: for Put and PutBlock, `[8:1]` is the byte write mask and `[0]` (alloc) is ignored. Ignored for Get and GetBlock.
- `io_in_acquire_bits_data` in 64.
- `io_in_grant_ready` in 1.
- `io_in_grant_valid` out 1.
- `io_in_grant_bits_addr_beat` out 3.
- `io_in_grant_bits_client_xact_id` out 2: echoes the Acquire value.
- `io_in_grant_bits_manager_xact_id` out 1: constant 0.
- `io_in_grant_bits_is_builtin_type` out 1: constant 1.
- `io_in_grant_bits_g_type` out 4: 3 putAck, 4 getDataBeat, 5 getDataBlock.
- `io_in_grant_bits_data` out 64.

## Operation
- The RAM index is `{addr_block[BLOCK_IDX_W-1:0], beat}`. Reads take one cycle. Writes are byte-masked and occur on the accepting clock edge. RAM contents are not reset.
- A beat is accepted when valid and ready are both high at a clock edge ("fire"). The responder latches `client_xact_id` on the first beat of every transaction.
- The state machine has five states: IDLE, PUT_BLK, RD_BEAT, RD_BLK, ACK.
- IDLE: `acquire_ready`=1, `grant_valid`=0. On acquire fire:
  - Get: issue a RAM read at `addr_beat`, go to RD_BEAT.
  - GetBlock: issue a read of beat 0, clear the beat counter, go to RD_BLK.
  - Put: write with the mask, go to ACK.
  - PutBlock: write the beat at the incoming `addr_beat`, set beat count=1, go to PUT_BLK.
  - Unsupported `a_type` or `is_builtin_type`=0: no RAM effect, go to RD_BEAT with data forced to 0.
- PUT_BLK: `acquire_ready`=1. Every fired beat is written at its own `addr_beat` and increments the count; `a_type` is not rechecked. When the 8th beat fires, go to ACK.
- ACK: one grant with `g_type`=3, `addr_beat`=0, data 0. Hold until `grant_ready`, then go to IDLE.
- RD_BEAT: one grant with `g_type`=4, `addr_beat` = the latched Acquire beat, data = RAM output (or 0 if unsupported). Hold until `grant_ready`, then go to IDLE.
- RD_BLK: stream beats 0..7 in order with `g_type`=5 and `addr_beat` = counter.
  - Read data is captured in an output register; the read for beat k+1 is issued on the cycle beat k fires.
  - While `grant_ready` is low, `grant_valid` stays high and the data stays stable.
  - When beat 7 fires, go to IDLE.
- `acquire_ready`=0 in every grant-producing state. Exactly one transaction is outstanding at a time.

## Timing
- Reset values: state IDLE, `io_in_grant_valid`=0, grant data/beat/xact_id=0, beat counter=0. `io_in_acquire_ready`=0 while `reset` is asserted and 1 on the first edge after deassert.
- Get/Put/unsupported: acquire fires at cycle N, `grant_valid` rises at N+1. With `grant_ready` held high, `acquire_ready` returns at N+2.
- GetBlock: acquire fires at N. With `grant_ready` held high, beats appear at N+1..N+8 (one per cycle), and `acquire_ready` returns at N+9.
- PutBlock: with `acquire_valid` high continuously, beats are accepted at N..N+7 and the putAck is valid at N+8.
- A Get to the same index as a Put that completed earlier returns the new data (write occurs before the grant; no bypass needed).
- `reset` asserted mid-transaction: the state machine aborts immediately to IDLE, the pending grant is dropped, and RAM writes already performed persist.
- All outputs come from registers or from a decode of the state; there is no combinational path from `io_in_acquire_*` to `io_in_grant_*`.

## Test plan
- Put at block 5, beat 2, data 0x1122334455667788, mask 0xFF, xact_id 1 -> putAck `g_type` 3, xact_id 1, at N+1. A following Get at the same address -> `g_type` 4, `addr_beat` 2, data 0x1122334455667788.
- Put with mask 0x0F, data 0xAAAAAAAABBBBBBBB over the contents 0x1122334455667788 -> a subsequent Get returns 0x11223344BBBBBBBB.
- PutBlock to block 3 with beats 0..7, data = beat*0x0101010101010101 -> exactly one putAck after the 8th beat. A GetBlock of block 3 -> 8 beats with `addr_beat` 0..7, matching data, `g_type` 5.
- GetBlock with `grant_ready` toggling 1,0,0,1,... -> data and `addr_beat` are held during stalls; no beat is lost or duplicated; `acquire_ready` stays 0 until beat 7 fires.
- `a_type`=4 -> grant `g_type` 4 with data 0, and RAM is unchanged (verified by a later Get).
- Assert `reset` during beat 3 of a GetBlock -> `grant_valid` drops asynchronously, and after deassert `acquire_ready`=1 and a new Get completes normally.

Source files
------------

// File: rtl/tile_link_uncached_ram_responder.sv
// Uncached TileLink manager endpoint: services Get/GetBlock/Put/PutBlock
// Acquires from an internal synchronous 64-bit RAM and returns Grants.
module tile_link_uncached_ram_responder #(
   parameter int unsigned BLOCK_IDX_W = 6,
   parameter int unsigned BEAT_W      = 3
) (
   input  logic              clk,
   input  logic              reset,
   output logic              io_in_acquire_ready,
   input  logic              io_in_acquire_valid,
   input  logic [25:0]       io_in_acquire_bits_addr_block,
   input  logic [1:0]        io_in_acquire_bits_client_xact_id,
   input  logic [BEAT_W-1:0] io_in_acquire_bits_addr_beat,
   input  logic              io_in_acquire_bits_is_builtin_type,
   input  logic [2:0]        io_in_acquire_bits_a_type,
   input  logic [11:0]       io_in_acquire_bits_union,
   input  logic [63:0]       io_in_acquire_bits_data,
   input  logic              io_in_grant_ready,
   output logic              io_in_grant_valid,
   output logic [BEAT_W-1:0] io_in_grant_bits_addr_beat,
   output logic [1:0]        io_in_grant_bits_client_xact_id,
   output logic              io_in_grant_bits_manager_xact_id,
   output logic              io_in_grant_bits_is_builtin_type,
   output logic [3:0]        io_in_grant_bits_g_type,
   output logic [63:0]       io_in_grant_bits_data
);

   localparam int unsigned IDX_W = BLOCK_IDX_W + BEAT_W;
   localparam int unsigned DEPTH = 2 ** IDX_W;

   typedef enum logic [2:0] {StIdle, StPutBlk, StRdBeat, StRdBlk, StAck} state_e;

   state_e state_q, state_d;

   logic                   ready_en_q;
   logic [1:0]             xid_q;
   logic [BLOCK_IDX_W-1:0] blk_q;
   logic [BEAT_W-1:0]      cnt_q;
   logic [BEAT_W-1:0]      gbeat_q;
   logic [63:0]            data_q;

   logic [63:0]            mem [DEPTH];

   logic                   acq_fire, gnt_fire;
   logic                   is_get, is_getblk, is_put, is_putblk, is_unsup;
   logic [BLOCK_IDX_W-1:0] blk_in;
   logic [BEAT_W-1:0]      cnt_inc, beat_sel;
   logic [IDX_W-1:0]       wr_idx, rd_idx;
   logic [63:0]            rd_data;
   logic [7:0]             wmask;
   logic                   mem_we;

   // Upper address bits alias and alloc/spare union bits carry no meaning here.
   logic unused_bits;
   assign unused_bits = ^{io_in_acquire_bits_union[11:9], io_in_acquire_bits_union[0],
                          io_in_acquire_bits_addr_block[25:BLOCK_IDX_W]};

   assign acq_fire  = io_in_acquire_valid && io_in_acquire_ready;
   assign gnt_fire  = io_in_grant_valid && io_in_grant_ready;
   assign is_get    = io_in_acquire_bits_is_builtin_type && (io_in_acquire_bits_a_type == 3'd0);
   assign is_getblk = io_in_acquire_bits_is_builtin_type && (io_in_acquire_bits_a_type == 3'd1);
   assign is_put    = io_in_acquire_bits_is_builtin_type && (io_in_acquire_bits_a_type == 3'd2);
   assign is_putblk = io_in_acquire_bits_is_builtin_type && (io_in_acquire_bits_a_type == 3'd3);
   assign is_unsup  = !(is_get || is_getblk || is_put || is_putblk);
   assign blk_in    = io_in_acquire_bits_addr_block[BLOCK_IDX_W-1:0];
   assign cnt_inc   = cnt_q + 1'b1;
   assign wmask     = io_in_acquire_bits_union[8:1];
   assign wr_idx    = {blk_in, io_in_acquire_bits_addr_beat};

   // Single RAM read port: prefetch of the next block beat, or the first read of a request.
   always_comb begin
      beat_sel = is_getblk ? '0 : io_in_acquire_bits_addr_beat;
      if (state_q == StRdBlk) rd_idx = {blk_q, cnt_inc};
      else                    rd_idx = {blk_in, beat_sel};
      rd_data = mem[rd_idx];
   end

   // Writes land on the accepting edge; PUT_BLK beats are written without rechecking a_type.
   always_comb begin
      mem_we = acq_fire && (((state_q == StIdle) && (is_put || is_putblk)) ||
                            (state_q == StPutBlk));
   end

   // Byte-masked RAM write; contents are deliberately not reset.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         for (int b = 0; b < 8; b++) begin
            if (wmask[b]) mem[wr_idx][8*b +: 8] <= io_in_acquire_bits_data[8*b +: 8];
         end
      end
   end

   // State register; ready_en holds acquire_ready low until the first edge out of reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= StIdle;
         ready_en_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         ready_en_q <= 1'b1;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle: begin
            if (acq_fire) begin
               if (is_getblk)      state_d = StRdBlk;
               else if (is_put)    state_d = StAck;
               else if (is_putblk) state_d = StPutBlk;
               else                state_d = StRdBeat;  // Get and unsupported
            end
         end
         StPutBlk: if (acq_fire && (cnt_q == '1)) state_d = StAck;
         StRdBeat: if (gnt_fire) state_d = StIdle;
         StAck:    if (gnt_fire) state_d = StIdle;
         StRdBlk:  if (gnt_fire && (cnt_q == '1)) state_d = StIdle;
         default:  state_d = StIdle;
      endcase
   end

   // Handshake and grant type decoded from state only.
   always_comb begin
      io_in_acquire_ready     = ready_en_q && ((state_q == StIdle) || (state_q == StPutBlk));
      io_in_grant_valid       = 1'b0;
      io_in_grant_bits_g_type = 4'd0;
      case (state_q)
         StAck: begin
            io_in_grant_valid       = 1'b1;
            io_in_grant_bits_g_type = 4'd3;
         end
         StRdBeat: begin
            io_in_grant_valid       = 1'b1;
            io_in_grant_bits_g_type = 4'd4;
         end
         StRdBlk: begin
            io_in_grant_valid       = 1'b1;
            io_in_grant_bits_g_type = 4'd5;
         end
         default: ;
      endcase
   end

   // Grant payload registers and beat counter.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         xid_q   <= '0;
         blk_q   <= '0;
         cnt_q   <= '0;
         gbeat_q <= '0;
         data_q  <= '0;
      end else begin
         case (state_q)
            StIdle: begin
               if (acq_fire) begin
                  xid_q   <= io_in_acquire_bits_client_xact_id;
                  blk_q   <= blk_in;
                  cnt_q   <= is_putblk ? BEAT_W'(1) : '0;
                  gbeat_q <= (is_get || is_unsup) ? io_in_acquire_bits_addr_beat : '0;
                  data_q  <= (is_get || is_getblk) ? rd_data : '0;
               end
            end
            StPutBlk: if (acq_fire) cnt_q <= cnt_inc;
            StRdBlk: begin
               // Next beat is fetched on the cycle the current one is taken.
               if (gnt_fire && (cnt_q != '1)) begin
                  cnt_q   <= cnt_inc;
                  gbeat_q <= cnt_inc;
                  data_q  <= rd_data;
               end
            end
            default: ;
         endcase
      end
   end

   assign io_in_grant_bits_addr_beat       = gbeat_q;
   assign io_in_grant_bits_client_xact_id  = xid_q;
   assign io_in_grant_bits_manager_xact_id = 1'b0;
   assign io_in_grant_bits_is_builtin_type = 1'b1;
   assign io_in_grant_bits_data            = data_q;

endmodule
